// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: EX/MEM register, req/ack data access with lane steering and load extension, MEM/WB register.
// Optional feature macro LSU_MISALIGN_EXC_EN: misaligned accesses are not issued and are flagged on MisalignW.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic [2:0]  ResultSrcE,
    input  logic [1:0]  StoreSrcE,
    input  logic [2:0]  LoadSrcE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RdE,
    input  logic        FlushM,
    output logic        DReq,
    output logic        DWe,
    output logic [31:0] DAddr,
    output logic [3:0]  DBe,
    output logic [31:0] DWData,
    input  logic        DAck,
    input  logic [31:0] DRData,
    output logic        StallM,
    output logic [31:0] ALUResultM,
    output logic        RegWriteM,
    output logic [4:0]  RdM,
`ifdef LSU_MISALIGN_EXC_EN
    output logic        MisalignW,
`endif
    output logic        RegWriteW,
    output logic [2:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;

    logic        regwrite_m_q, memwrite_m_q;
    logic [2:0]  resultsrc_m_q, loadsrc_m_q;
    logic [1:0]  storesrc_m_q;
    logic [31:0] aluresult_m_q, writedata_m_q, pcplus4_m_q;
    logic [4:0]  rd_m_q;

    logic        regwrite_w_q;
    logic [2:0]  resultsrc_w_q;
    logic [4:0]  rd_w_q;
    logic [31:0] aluresult_w_q, readdata_w_q, pcplus4_w_q;

    logic        is_load_m, misalign_m, mem_op_m;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // EX/MEM: frozen while the data access is outstanding
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regwrite_m_q  <= 1'b0;
            memwrite_m_q  <= 1'b0;
            resultsrc_m_q <= '0;
            storesrc_m_q  <= '0;
            loadsrc_m_q   <= '0;
            aluresult_m_q <= '0;
            writedata_m_q <= '0;
            pcplus4_m_q   <= '0;
            rd_m_q        <= '0;
        end else if (!StallM) begin
            regwrite_m_q  <= RegWriteE & ~FlushM;
            memwrite_m_q  <= MemWriteE & ~FlushM;
            resultsrc_m_q <= FlushM ? 3'b000 : ResultSrcE;
            storesrc_m_q  <= StoreSrcE;
            loadsrc_m_q   <= LoadSrcE;
            aluresult_m_q <= ALUResultE;
            writedata_m_q <= WriteDataE;
            pcplus4_m_q   <= PCPlus4E;
            rd_m_q        <= RdE;
        end
    end

    assign is_load_m = (resultsrc_m_q == 3'b001);

`ifdef LSU_MISALIGN_EXC_EN
    always_comb begin
        misalign_m = 1'b0;
        if (memwrite_m_q) begin
            case (storesrc_m_q)
                2'b01:   misalign_m = aluresult_m_q[0];
                2'b10:   misalign_m = 1'b0;
                default: misalign_m = (aluresult_m_q[1:0] != 2'b00);
            endcase
        end else if (is_load_m) begin
            case (loadsrc_m_q)
                3'b001, 3'b011: misalign_m = aluresult_m_q[0];
                3'b010, 3'b100: misalign_m = 1'b0;
                default:        misalign_m = (aluresult_m_q[1:0] != 2'b00);
            endcase
        end
    end
`else
    assign misalign_m = 1'b0;
`endif

    assign mem_op_m = (memwrite_m_q | is_load_m) & ~misalign_m;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        DReq    = 1'b0;
        case (state_q)
            S_IDLE: begin
                DReq = mem_op_m;
                if (mem_op_m && !DAck) state_d = S_WAIT;
            end
            S_WAIT: begin
                DReq = 1'b1;
                if (DAck) state_d = S_IDLE;
            end
        endcase
    end

    assign StallM = DReq & ~DAck;
    assign DWe    = DReq & memwrite_m_q;
    assign DAddr  = {aluresult_m_q[31:2], 2'b00};

    always_comb begin
        DBe    = 4'b0000;
        DWData = writedata_m_q;
        if (memwrite_m_q) begin
            case (storesrc_m_q)
                2'b01: begin
                    DBe    = aluresult_m_q[1] ? 4'b1100 : 4'b0011;
                    DWData = {2{writedata_m_q[15:0]}};
                end
                2'b10: begin
                    DBe    = 4'b0001 << aluresult_m_q[1:0];
                    DWData = {4{writedata_m_q[7:0]}};
                end
                default: DBe = 4'b1111;
            endcase
        end else if (is_load_m) begin
            DBe = 4'b1111;
        end
    end

    always_comb begin
        ld_byte = DRData[7:0];
        case (aluresult_m_q[1:0])
            2'd0: ld_byte = DRData[7:0];
            2'd1: ld_byte = DRData[15:8];
            2'd2: ld_byte = DRData[23:16];
            2'd3: ld_byte = DRData[31:24];
        endcase
        ld_half = aluresult_m_q[1] ? DRData[31:16] : DRData[15:0];
        case (loadsrc_m_q)
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b011:  ld_ext = {16'h0000, ld_half};
            3'b010:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h000000, ld_byte};
            default: ld_ext = DRData;
        endcase
    end

    // MEM/WB: a stall cycle writes a bubble; suppressed accesses never write the register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regwrite_w_q  <= 1'b0;
            resultsrc_w_q <= '0;
            rd_w_q        <= '0;
            aluresult_w_q <= '0;
            readdata_w_q  <= '0;
            pcplus4_w_q   <= '0;
        end else begin
            regwrite_w_q  <= regwrite_m_q & ~StallM & ~misalign_m;
            resultsrc_w_q <= resultsrc_m_q;
            rd_w_q        <= rd_m_q;
            aluresult_w_q <= aluresult_m_q;
            readdata_w_q  <= (is_load_m & ~misalign_m) ? ld_ext : '0;
            pcplus4_w_q   <= pcplus4_m_q;
        end
    end

`ifdef LSU_MISALIGN_EXC_EN
    logic misalign_w_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) misalign_w_q <= 1'b0;
        else          misalign_w_q <= misalign_m & ~StallM;
    end

    assign MisalignW = misalign_w_q;
`endif

    assign ALUResultM = aluresult_m_q;
    assign RegWriteM  = regwrite_m_q;
    assign RdM        = rd_m_q;
    assign RegWriteW  = regwrite_w_q;
    assign ResultSrcW = resultsrc_w_q;
    assign RdW        = rd_w_q;
    assign ALUResultW = aluresult_w_q;
    assign ReadDataW  = readdata_w_q;
    assign PCPlus4W   = pcplus4_w_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized ops against a byte-lane reference model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        RegWriteE, MemWriteE, FlushM, DAck;
    logic [2:0]  ResultSrcE, LoadSrcE;
    logic [1:0]  StoreSrcE;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E, DRData;
    logic [4:0]  RdE;
    logic        DReq, DWe, StallM, RegWriteM, RegWriteW;
    logic [31:0] DAddr, DWData, ALUResultM, ALUResultW, ReadDataW, PCPlus4W;
    logic [3:0]  DBe;
    logic [4:0]  RdM, RdW;
    logic [2:0]  ResultSrcW;
`ifdef LSU_MISALIGN_EXC_EN
    logic        MisalignW;
`endif

    int vectors = 0;
    int miscompares = 0;

    mem_stage_lsu dut (
        .clk(clk), .reset_n(reset_n),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .StoreSrcE(StoreSrcE), .LoadSrcE(LoadSrcE), .ALUResultE(ALUResultE),
        .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE), .FlushM(FlushM),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DBe(DBe), .DWData(DWData),
        .DAck(DAck), .DRData(DRData), .StallM(StallM), .ALUResultM(ALUResultM),
        .RegWriteM(RegWriteM), .RdM(RdM),
`ifdef LSU_MISALIGN_EXC_EN
        .MisalignW(MisalignW),
`endif
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        regwrite;
        logic        memwrite;
        logic [2:0]  rsrc;
        logic [1:0]  ssrc;
        logic [2:0]  lsrc;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic        req;
        logic [31:0] daddr;
        logic [3:0]  dbe;
        logic        dwe;
        logic [31:0] dwdata;
        logic        bus_stable;
        int          stall_cycles;
        int          bubbles;
        logic        stall_at_ack;
        logic [31:0] alum;
        logic        regwm;
        logic [4:0]  rdm;
        logic        regww;
        logic [2:0]  rsw;
        logic [4:0]  rdw;
        logic [31:0] aluw;
        logic [31:0] rdataw;
        logic [31:0] pcw;
        logic        misw;
    } obs_t;

    typedef struct {
        logic        req;
        logic        mis;
        logic [31:0] daddr;
        logic [3:0]  dbe;
        logic        dwe;
        logic [31:0] dwdata;
        logic        regww;
        logic [31:0] rdataw;
    } exp_t;

    // Reference: an access is `size` bytes at byte offset `lane` in the addressed word.
    function automatic void model(input op_t op, input logic [31:0] rdata, output exp_t e);
        bit     is_st, is_ld, sgn, memop;
        int     size, lane;
        longint m, v, chunk, d;
        is_st = op.memwrite;
        is_ld = (op.rsrc == 3'd1);
        if (is_st) size = (op.ssrc == 2'd1) ? 2 : (op.ssrc == 2'd2) ? 1 : 4;
        else       size = (op.lsrc == 3'd1 || op.lsrc == 3'd3) ? 2 :
                          (op.lsrc == 3'd2 || op.lsrc == 3'd4) ? 1 : 4;
        sgn = (op.lsrc == 3'd1 || op.lsrc == 3'd2);
`ifdef LSU_MISALIGN_EXC_EN
        e.mis = (is_st || is_ld) && ((op.alu % size) != 0);
`else
        e.mis = 1'b0;
`endif
        memop  = (is_st || is_ld) && !e.mis;
        lane   = (int'(op.alu % 4) / size) * size;
        m      = longint'(1) << (8 * size);
        e.req  = memop;
        e.daddr = op.alu & 32'hFFFF_FFFC;
        e.dwe  = is_st;
        e.dbe  = is_st ? 4'(((1 << size) - 1) << lane) : 4'hF;
        chunk  = longint'({32'd0, op.wd}) % m;
        d      = 0;
        for (int i = 0; i < 4 / size; i++) d += chunk << (8 * size * i);
        e.dwdata = 32'(d);
        v = (longint'({32'd0, rdata}) >> (8 * lane)) % m;
        if (sgn && v >= m / 2) v = v - m;
        e.rdataw = (is_ld && !e.mis) ? 32'(v) : 32'd0;
        e.regww  = op.regwrite && !e.mis;
    endfunction

    task automatic nop_e();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; StoreSrcE = 0; LoadSrcE = 0;
        ALUResultE = 0; WriteDataE = 0; PCPlus4E = 0; RdE = 0; FlushM = 0;
    endtask

    // Entered and left #1 after a rising edge; issues op, answers the request after `waits` wait states.
    task automatic run_op(input op_t op, input int waits, input logic [31:0] rdata,
                          input logic flush_e, input logic flush_in_m, output obs_t o);
        logic first;
        RegWriteE = op.regwrite; MemWriteE = op.memwrite; ResultSrcE = op.rsrc;
        StoreSrcE = op.ssrc; LoadSrcE = op.lsrc; ALUResultE = op.alu;
        WriteDataE = op.wd; PCPlus4E = op.pc; RdE = op.rd; FlushM = flush_e;
        DAck = 0;
        @(posedge clk); #1;
        nop_e();
        o.alum = ALUResultM; o.regwm = RegWriteM; o.rdm = RdM;
        o.req = DReq; o.stall_cycles = 0; o.bubbles = 0; o.bus_stable = 1'b1;
        o.daddr = '0; o.dbe = '0; o.dwe = 1'b0; o.dwdata = '0;
        first = 1'b1;
        if (o.req) begin
            for (int k = 0; k <= waits; k++) begin
                if (k == waits) begin
                    FlushM = 0; DAck = 1; DRData = rdata;
                end else begin
                    FlushM = flush_in_m; DAck = 0; DRData = $urandom;
                end
                @(negedge clk);
                if (first) begin
                    o.daddr = DAddr; o.dbe = DBe; o.dwe = DWe; o.dwdata = DWData;
                    first = 1'b0;
                end else if ({DAddr, DBe, DWe, DWData, DReq} !== {o.daddr, o.dbe, o.dwe, o.dwdata, 1'b1}) begin
                    o.bus_stable = 1'b0;
                end
                if (k == waits) o.stall_at_ack = StallM;
                else if (StallM) o.stall_cycles++;
                @(posedge clk); #1;
                if (k < waits && !RegWriteW) o.bubbles++;
            end
            DAck = 0;
        end else begin
            @(negedge clk);
            o.stall_at_ack = StallM;
            @(posedge clk); #1;
        end
        o.regww = RegWriteW; o.rsw = ResultSrcW; o.rdw = RdW;
        o.aluw = ALUResultW; o.rdataw = ReadDataW; o.pcw = PCPlus4W;
`ifdef LSU_MISALIGN_EXC_EN
        o.misw = MisalignW;
`else
        o.misw = 1'b0;
`endif
    endtask

    function automatic op_t mk(input logic rw, input logic mw, input logic [2:0] rs, input logic [1:0] ss,
                               input logic [2:0] ls, input logic [31:0] a, input logic [31:0] wd,
                               input logic [4:0] rd);
        op_t op;
        op.regwrite = rw; op.memwrite = mw; op.rsrc = rs; op.ssrc = ss; op.lsrc = ls;
        op.alu = a; op.wd = wd; op.pc = a + 32'h100; op.rd = rd;
        return op;
    endfunction

    task automatic test_reset();
        reset_n = 0; nop_e(); DAck = 0; DRData = 0;
        @(negedge clk);
        vectors++;
        if ({DReq, DWe, DAddr, DBe, DWData, StallM, ALUResultM, RegWriteM, RdM, RegWriteW, ResultSrcW,
             RdW, ALUResultW, ReadDataW, PCPlus4W} !== '0) begin
            miscompares++; $display("FAIL reset_outputs: some output nonzero (DReq=%b DBe=%b RegWriteW=%b), expected all 0", DReq, DBe, RegWriteW);
        end
        @(posedge clk); #1; reset_n = 1;
        @(negedge clk);
        vectors++;
        if ({DReq, StallM, RegWriteW} !== 3'b000) begin
            miscompares++; $display("FAIL idle_after_reset: DReq/StallM/RegWriteW=%b expected 000", {DReq, StallM, RegWriteW});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        obs_t o;
        run_op(mk(1, 0, 3'd0, 2'd0, 3'd0, 32'h10, 32'h0, 5'd5), 0, 32'h0, 0, 0, o);
        vectors++;
        if (o.alum !== 32'h10) begin
            miscompares++; $display("FAIL alu_ALUResultM: got %h expected 00000010", o.alum);
        end
        vectors++;
        if ({o.req, o.regww, o.rdw, o.aluw, o.rdataw} !== {1'b0, 1'b1, 5'd5, 32'h10, 32'h0}) begin
            miscompares++; $display("FAIL alu_writeback: req=%b RegWriteW=%b RdW=%0d ALUResultW=%h ReadDataW=%h expected 0 1 5 00000010 00000000",
                                    o.req, o.regww, o.rdw, o.aluw, o.rdataw);
        end
    endtask

    task automatic test_store_sb();
        obs_t o;
        run_op(mk(0, 1, 3'd0, 2'd2, 3'd0, 32'h1003, 32'hAB, 5'd0), 0, 32'h0, 0, 0, o);
        vectors++;
        if ({o.req, o.dwe, o.dbe, o.dwdata, o.daddr} !== {1'b1, 1'b1, 4'b1000, 32'hABABABAB, 32'h1000}) begin
            miscompares++; $display("FAIL sb_bus: req=%b DWe=%b DBe=%b DWData=%h DAddr=%h expected 1 1 1000 abababab 00001000",
                                    o.req, o.dwe, o.dbe, o.dwdata, o.daddr);
        end
        vectors++;
        if ({o.stall_cycles != 0, o.stall_at_ack} !== 2'b00) begin
            miscompares++; $display("FAIL sb_zero_wait_stall: stall_cycles=%0d stall_at_ack=%b expected 0 0", o.stall_cycles, o.stall_at_ack);
        end
    endtask

    task automatic test_load_wait();
        obs_t o;
        logic [31:0] want [2] = '{32'hFFFFFF80, 32'h00000080};
        logic [2:0]  ls   [2] = '{3'd2, 3'd4};
        for (int i = 0; i < 2; i++) begin
            run_op(mk(1, 0, 3'd1, 2'd0, ls[i], 32'h2001, 32'h0, 5'd9), 3, 32'h00008000, 0, 0, o);
            vectors++;
            if ({o.stall_cycles, o.bubbles} !== {32'd3, 32'd3}) begin
                miscompares++; $display("FAIL load_wait_stalls[%0d]: stall_cycles=%0d bubbles=%0d expected 3 3", i, o.stall_cycles, o.bubbles);
            end
            vectors++;
            if ({o.regww, o.rdw, o.rdataw} !== {1'b1, 5'd9, want[i]}) begin
                miscompares++; $display("FAIL load_wait_data[%0d]: RegWriteW=%b RdW=%0d ReadDataW=%h expected 1 9 %h", i, o.regww, o.rdw, o.rdataw, want[i]);
            end
        end
        run_op(mk(1, 0, 3'd1, 2'd0, 3'd1, 32'h2002, 32'h0, 5'd3), 0, 32'h7FFF1234, 0, 0, o);
        vectors++;
        if ({o.rdataw, o.stall_at_ack, o.dbe} !== {32'h00007FFF, 1'b0, 4'hF}) begin
            miscompares++; $display("FAIL lh_zero_wait: ReadDataW=%h stall=%b DBe=%b expected 00007fff 0 1111", o.rdataw, o.stall_at_ack, o.dbe);
        end
    endtask

    task automatic test_reset_midwait();
        RegWriteE = 1; ResultSrcE = 3'd1; LoadSrcE = 3'd0; ALUResultE = 32'h4000; RdE = 5'd4; DAck = 0;
        @(posedge clk); #1;
        nop_e();
        @(negedge clk);
        vectors++;
        if ({DReq, StallM} !== 2'b11) begin
            miscompares++; $display("FAIL midwait_pre: DReq/StallM=%b expected 11", {DReq, StallM});
        end
        #2; reset_n = 0; #1;
        vectors++;
        if ({DReq, StallM} !== 2'b00) begin
            miscompares++; $display("FAIL midwait_async_drop: DReq/StallM=%b expected 00", {DReq, StallM});
        end
        @(posedge clk); #1; reset_n = 1;
        @(negedge clk);
        vectors++;
        if ({DReq, StallM, RegWriteM, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W} !== '0) begin
            miscompares++; $display("FAIL midwait_after_release: DReq=%b StallM=%b RegWriteW=%b ReadDataW=%h expected all 0",
                                    DReq, StallM, RegWriteW, ReadDataW);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        obs_t o;
        exp_t e;
        op_t  op;
        run_op(mk(1, 0, 3'd0, 2'd0, 3'd0, 32'h55, 32'h0, 5'd6), 0, 32'h0, 1, 0, o);
        vectors++;
        if ({o.regwm, o.regww} !== 2'b00) begin
            miscompares++; $display("FAIL flush_alu: RegWriteM=%b RegWriteW=%b expected 0 0", o.regwm, o.regww);
        end
        run_op(mk(0, 1, 3'd0, 2'd0, 3'd0, 32'h60, 32'h1234, 5'd0), 0, 32'h0, 1, 0, o);
        vectors++;
        if (o.req !== 1'b0) begin
            miscompares++; $display("FAIL flush_store: DReq=%b expected 0", o.req);
        end
        op = mk(1, 0, 3'd1, 2'd0, 3'd3, 32'h5002, 32'h0, 5'd12);
        model(op, 32'h9ABC1357, e);
        run_op(op, 2, 32'h9ABC1357, 0, 1, o);
        vectors++;
        if ({o.stall_cycles, o.regww, o.rdw, o.rdataw} !== {32'd2, 1'b1, 5'd12, e.rdataw}) begin
            miscompares++; $display("FAIL flush_during_stall: stalls=%0d RegWriteW=%b RdW=%0d ReadDataW=%h expected 2 1 12 %h",
                                    o.stall_cycles, o.regww, o.rdw, o.rdataw, e.rdataw);
        end
    endtask

    task automatic test_dack_idle();
        DAck = 1; DRData = 32'hDEADBEEF;
        @(negedge clk);
        vectors++;
        if ({DReq, StallM} !== 2'b00) begin
            miscompares++; $display("FAIL dack_idle: DReq/StallM=%b expected 00", {DReq, StallM});
        end
        @(posedge clk); #1; DAck = 0;
        vectors++;
        if ({RegWriteW, ReadDataW} !== 33'd0) begin
            miscompares++; $display("FAIL dack_idle_w: RegWriteW=%b ReadDataW=%h expected 0 00000000", RegWriteW, ReadDataW);
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        run_op(mk(1, 0, 3'd1, 2'd0, 3'd0, 32'h3002, 32'h0, 5'd7), 0, 32'h11223344, 0, 0, o);
`ifdef LSU_MISALIGN_EXC_EN
        vectors++;
        if ({o.req, o.stall_at_ack, o.misw, o.regww} !== 4'b0010) begin
            miscompares++; $display("FAIL misalign_lw: DReq=%b StallM=%b MisalignW=%b RegWriteW=%b expected 0 0 1 0",
                                    o.req, o.stall_at_ack, o.misw, o.regww);
        end
`else
        vectors++;
        if ({o.req, o.daddr, o.rdataw} !== {1'b1, 32'h3000, 32'h11223344}) begin
            miscompares++; $display("FAIL misalign_lw: DReq=%b DAddr=%h ReadDataW=%h expected 1 00003000 11223344", o.req, o.daddr, o.rdataw);
        end
`endif
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        op_t  op;
        int   kind, waits;
        logic [31:0] rdata;
        logic [2:0]  alu_rs [3] = '{3'd0, 3'd2, 3'd4};
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 8);
            op = mk(1'($urandom), 0, alu_rs[$urandom_range(0, 2)], 2'd0, 3'd0, $urandom, $urandom, 5'($urandom));
            if (kind >= 2 && kind <= 4) begin
                op.memwrite = 1; op.regwrite = 0; op.rsrc = 3'd0; op.ssrc = 2'($urandom_range(0, 2));
            end else if (kind >= 5) begin
                op.regwrite = 1; op.rsrc = 3'd1; op.lsrc = 3'($urandom_range(0, 4));
            end
            waits = $urandom_range(0, 3);
            rdata = $urandom;
            model(op, rdata, e);
            run_op(op, waits, rdata, 0, 0, o);
            vectors++;
            if ({o.alum, o.rdm, o.regwm} !== {op.alu, op.rd, op.regwrite}) begin
                miscompares++; $display("FAIL rand%0d_mstage: ALUResultM=%h RdM=%0d RegWriteM=%b expected %h %0d %b",
                                        n, o.alum, o.rdm, o.regwm, op.alu, op.rd, op.regwrite);
            end
            vectors++;
            if (o.req !== e.req) begin
                miscompares++; $display("FAIL rand%0d_req: DReq=%b expected %b", n, o.req, e.req);
            end else if (e.req) begin
                vectors++;
                if ({o.daddr, o.dbe, o.dwe} !== {e.daddr, e.dbe, e.dwe} || (e.dwe && o.dwdata !== e.dwdata)) begin
                    miscompares++; $display("FAIL rand%0d_bus: DAddr=%h DBe=%b DWe=%b DWData=%h expected %h %b %b %h",
                                            n, o.daddr, o.dbe, o.dwe, o.dwdata, e.daddr, e.dbe, e.dwe, e.dwdata);
                end
                vectors++;
                if ({o.bus_stable, o.stall_at_ack, o.stall_cycles, o.bubbles} !== {1'b1, 1'b0, waits, waits}) begin
                    miscompares++; $display("FAIL rand%0d_stall: stable=%b stall_at_ack=%b stalls=%0d bubbles=%0d expected 1 0 %0d %0d",
                                            n, o.bus_stable, o.stall_at_ack, o.stall_cycles, o.bubbles, waits, waits);
                end
            end
            vectors++;
            if ({o.regww, o.rsw, o.rdw, o.aluw, o.pcw, o.rdataw, o.misw} !==
                {e.regww, op.rsrc, op.rd, op.alu, op.pc, e.rdataw, e.mis}) begin
                miscompares++; $display("FAIL rand%0d_wb: RegWriteW=%b ResultSrcW=%0d RdW=%0d ALUResultW=%h PCPlus4W=%h ReadDataW=%h MisalignW=%b expected %b %0d %0d %h %h %h %b",
                                        n, o.regww, o.rsw, o.rdw, o.aluw, o.pcw, o.rdataw, o.misw,
                                        e.regww, op.rsrc, op.rd, op.alu, op.pc, e.rdataw, e.mis);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_store_sb();
        test_load_wait();
        test_reset_midwait();
        test_flush();
        test_dack_idle();
        test_misalign();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
